// File: rtl/wb_regfile.sv
// Write-back stage and 32 x XLEN architectural register file with a pending-write FIFO.
// Define WB_BYPASS_EN to let the read ports bypass from pending FIFO entries.
module wb_regfile #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_wen,
  input  logic [4:0]      in_rd,
  input  logic [XLEN-1:0] in_v,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  output logic [XLEN-1:0] rs1_v,
  output logic [XLEN-1:0] rs2_v,
  output logic            busy,
  output logic [31:0]     wr_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [4:0]      fifo_rd_q [DEPTH];
  logic [4:0]      fifo_rd_d [DEPTH];
  logic [XLEN-1:0] fifo_v_q  [DEPTH];
  logic [XLEN-1:0] fifo_v_d  [DEPTH];
  logic [XLEN-1:0] regs_q    [32];
  logic [XLEN-1:0] regs_d    [32];
  logic [31:0]     wr_cnt_q, wr_cnt_d;

  logic            empty;
  logic            full;
  logic            push;
  logic            pop;
  logic [4:0]      head_rd;
  logic [XLEN-1:0] head_v;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign in_ready = !full;
  assign busy     = !empty;
  assign wr_cnt   = wr_cnt_q;

  // Results that do not write a register are consumed without occupying a slot.
  assign push    = in_valid && in_ready && in_wen && (in_rd != 5'd0);
  assign pop     = !empty;
  assign head_rd = fifo_rd_q[rd_ptr_q[AW-1:0]];
  assign head_v  = fifo_v_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    fifo_rd_d = fifo_rd_q;
    fifo_v_d  = fifo_v_q;
    regs_d    = regs_q;
    wr_cnt_d  = wr_cnt_q;
    if (push) begin
      fifo_rd_d[wr_ptr_q[AW-1:0]] = in_rd;
      fifo_v_d[wr_ptr_q[AW-1:0]]  = in_v;
      wr_ptr_d                    = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
      wr_cnt_d = wr_cnt_q + 32'd1;
      if (head_rd != 5'd0) begin
        regs_d[head_rd] = head_v;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      wr_cnt_q <= '0;
      for (int unsigned i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
      for (int unsigned i = 0; i < DEPTH; i++) begin
        fifo_rd_q[i] <= '0;
        fifo_v_q[i]  <= '0;
      end
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_cnt_q  <= wr_cnt_d;
      regs_q    <= regs_d;
      fifo_rd_q <= fifo_rd_d;
      fifo_v_q  <= fifo_v_d;
    end
  end

`ifdef WB_BYPASS_EN
  logic [PW-1:0] count;
  assign count = wr_ptr_q - rd_ptr_q;
`endif

  always_comb begin
`ifdef WB_BYPASS_EN
    logic [PW-1:0] slot;
    slot = '0;
`endif
    rs1_v = regs_q[rs1];
    rs2_v = regs_q[rs2];
`ifdef WB_BYPASS_EN
    // Scan oldest to newest so the newest matching pending entry wins.
    for (int unsigned k = 0; k < DEPTH; k++) begin
      slot = rd_ptr_q + PW'(k);
      if (PW'(k) < count) begin
        if (fifo_rd_q[slot[AW-1:0]] == rs1) rs1_v = fifo_v_q[slot[AW-1:0]];
        if (fifo_rd_q[slot[AW-1:0]] == rs2) rs2_v = fifo_v_q[slot[AW-1:0]];
      end
    end
`endif
    if (rs1 == 5'd0) rs1_v = '0;
    if (rs2 == 5'd0) rs2_v = '0;
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_wb_regfile;

  localparam int XLEN  = 32;
  localparam int DEPTH = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic            in_wen;
  logic [4:0]      in_rd;
  logic [XLEN-1:0] in_v;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [XLEN-1:0] rs1_v;
  logic [XLEN-1:0] rs2_v;
  logic            busy;
  logic [31:0]     wr_cnt;

  always #5 clk = ~clk;

  wb_regfile #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_wen   (in_wen),
    .in_rd    (in_rd),
    .in_v     (in_v),
    .rs1      (rs1),
    .rs2      (rs2),
    .rs1_v    (rs1_v),
    .rs2_v    (rs2_v),
    .busy     (busy),
    .wr_cnt   (wr_cnt)
  );

  // Reference model: architectural array, ordered list of pending writes, write counter.
  logic [31:0] m_regs [32];
  logic [4:0]  q_rd [$];
  logic [31:0] q_v [$];
  logic [31:0] m_cnt;

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] m_read(input logic [4:0] idx);
    logic [31:0] r;
    if (idx == 5'd0) return 32'd0;
    r = m_regs[idx];
`ifdef WB_BYPASS_EN
    foreach (q_rd[i]) if (q_rd[i] == idx) r = q_v[i];
`endif
    return r;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    q_rd.delete();
    q_v.delete();
    m_cnt = 32'd0;
  endtask

  // Drive one cycle of stimulus, advance the model at the edge, return 1 time unit after it.
  task automatic cycle(input logic r, input logic v, input logic wen, input logic [4:0] rd,
                       input logic [31:0] val);
    bit can_take;
    @(negedge clk);
    rst = r; in_valid = v; in_wen = wen; in_rd = rd; in_v = val;
    @(posedge clk);
    if (r) begin
      m_clear();
    end else begin
      can_take = (q_rd.size() < DEPTH);
      if (q_rd.size() > 0) begin
        m_regs[q_rd[0]] = q_v[0];
        void'(q_rd.pop_front());
        void'(q_v.pop_front());
        m_cnt = m_cnt + 32'd1;
      end
      if (v && can_take && wen && rd != 5'd0) begin
        q_rd.push_back(rd);
        q_v.push_back(val);
      end
    end
    #1;
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic test_reset();
    cycle(1'b1, 1'b1, 1'b1, 5'd5, 32'h1111_2222);
    cycle(1'b1, 1'b1, 1'b1, 5'd5, 32'h3333_4444);
    idle();
    rs1 = 5'd5; rs2 = 5'd0; #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", in_ready); end
    checks++; if (wr_cnt !== 32'd0) begin errors++; $display("FAIL reset_wr_cnt got %h want 0", wr_cnt); end
    checks++; if (rs1_v !== 32'd0) begin errors++; $display("FAIL reset_x5 got %h want 0", rs1_v); end
  endtask

  task automatic test_single_write();
    rs1 = 5'd5;
    cycle(1'b0, 1'b1, 1'b1, 5'd5, 32'hDEAD_BEEF);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b want 1", busy); end
    checks++; if (rs1_v !== m_read(5'd5)) begin errors++; $display("FAIL single_bypass got %h want %h", rs1_v, m_read(5'd5)); end
    idle();
    checks++; if (rs1_v !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_array got %h want deadbeef", rs1_v); end
    checks++; if (wr_cnt !== 32'd1) begin errors++; $display("FAIL single_wr_cnt got %h want 1", wr_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_drained got %b want 0", busy); end
  endtask

  task automatic test_newest_wins();
    rs2 = 5'd7;
    cycle(1'b0, 1'b1, 1'b1, 5'd7, 32'd1);
    cycle(1'b0, 1'b1, 1'b1, 5'd7, 32'd2);
    checks++; if (rs2_v !== m_read(5'd7)) begin errors++; $display("FAIL newest_bypass got %h want %h", rs2_v, m_read(5'd7)); end
    idle();
    checks++; if (rs2_v !== 32'd2) begin errors++; $display("FAIL newest_array got %h want 2", rs2_v); end
    checks++; if (wr_cnt !== 32'd3) begin errors++; $display("FAIL newest_wr_cnt got %h want 3", wr_cnt); end
  endtask

  task automatic test_filter();
    logic [31:0] cnt0;
    cnt0 = m_cnt;
    rs1 = 5'd0; rs2 = 5'd3;
    cycle(1'b0, 1'b1, 1'b1, 5'd0, 32'hFFFF_FFFF);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL filter_x0_busy got %b want 0", busy); end
    cycle(1'b0, 1'b1, 1'b0, 5'd3, 32'hAAAA_5555);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL filter_nowen_busy got %b want 0", busy); end
    idle();
    checks++; if (rs1_v !== 32'd0) begin errors++; $display("FAIL filter_x0 got %h want 0", rs1_v); end
    checks++; if (rs2_v !== 32'd0) begin errors++; $display("FAIL filter_x3 got %h want 0", rs2_v); end
    checks++; if (wr_cnt !== cnt0) begin errors++; $display("FAIL filter_wr_cnt got %h want %h", wr_cnt, cnt0); end
  endtask

  task automatic test_reset_mid();
    rs1 = 5'd9;
    cycle(1'b0, 1'b1, 1'b1, 5'd9, 32'h55);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rmid_busy_pre got %b want 1", busy); end
    cycle(1'b1, 1'b1, 1'b1, 5'd9, 32'h66);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b want 0", busy); end
    checks++; if (wr_cnt !== 32'd0) begin errors++; $display("FAIL rmid_wr_cnt got %h want 0", wr_cnt); end
    checks++; if (rs1_v !== 32'd0) begin errors++; $display("FAIL rmid_x9 got %h want 0", rs1_v); end
    idle();
    checks++; if (rs1_v !== 32'd0) begin errors++; $display("FAIL rmid_x9_late got %h want 0", rs1_v); end
    checks++; if (wr_cnt !== 32'd0) begin errors++; $display("FAIL rmid_wr_cnt_late got %h want 0", wr_cnt); end
  endtask

  task automatic test_random();
    logic       r, v, w;
    logic [4:0] rd;
    for (int n = 0; n < 400; n++) begin
      r  = ($urandom_range(0, 59) == 0);
      v  = ($urandom_range(0, 3) != 0);
      w  = ($urandom_range(0, 5) != 0);
      rd = 5'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) rd = 5'($urandom_range(0, 31));
      rs1 = 5'($urandom_range(0, 8));
      rs2 = 5'($urandom_range(0, 8));
      cycle(r, v, w, rd, $urandom);
      checks++; if (rs1_v !== m_read(rs1)) begin errors++; $display("FAIL rand_rs1 n=%0d x%0d got %h want %h", n, rs1, rs1_v, m_read(rs1)); end
      checks++; if (rs2_v !== m_read(rs2)) begin errors++; $display("FAIL rand_rs2 n=%0d x%0d got %h want %h", n, rs2, rs2_v, m_read(rs2)); end
      checks++; if (busy !== (q_rd.size() != 0)) begin errors++; $display("FAIL rand_busy n=%0d got %b want %b", n, busy, q_rd.size() != 0); end
      checks++; if (in_ready !== (q_rd.size() < DEPTH)) begin errors++; $display("FAIL rand_ready n=%0d got %b", n, in_ready); end
      checks++; if (wr_cnt !== m_cnt) begin errors++; $display("FAIL rand_wr_cnt n=%0d got %h want %h", n, wr_cnt, m_cnt); end
    end
  endtask

  task automatic test_counter_wrap();
    idle();
    idle();
    force dut.wr_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.wr_cnt_q;
    m_cnt = 32'hFFFF_FFFF;
    rs1 = 5'd4;
    cycle(1'b0, 1'b1, 1'b1, 5'd4, 32'h1234);
    checks++; if (wr_cnt !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_pre got %h want ffffffff", wr_cnt); end
    idle();
    checks++; if (wr_cnt !== 32'd0) begin errors++; $display("FAIL wrap_cnt got %h want 0", wr_cnt); end
    checks++; if (rs1_v !== 32'h1234) begin errors++; $display("FAIL wrap_x4 got %h want 1234", rs1_v); end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_wen = 1'b0; in_rd = '0; in_v = '0; rs1 = '0; rs2 = '0;
    m_clear();
    test_reset();
    test_single_write();
    test_newest_wins();
    test_filter();
    test_reset_mid();
    test_random();
    test_counter_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
